// File: rtl/fft_r2sdf_stage_32b.sv
// Radix-2 single-path delay-feedback DIF butterfly stage: sums stream out in phase 1,
// differences are parked in the delay line and stream out, twiddle-flagged, in the next phase 0.
module fft_r2sdf_stage_32b #(
  parameter int unsigned DELAY = 32,
  parameter bit          SCALE = 1'b1,
  localparam int unsigned TW_W  = (DELAY > 1) ? $clog2(DELAY) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [31:0]     in_data,
  output logic            out_valid,
  output logic [31:0]     out_data,
  output logic            out_tw_en,
  output logic [TW_W-1:0] out_tw_idx
);

  localparam int unsigned CNT_W = $clog2(2 * DELAY);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             primed_q, primed_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_tw_en_q, out_tw_en_d;
  logic [TW_W-1:0]  out_tw_idx_q, out_tw_idx_d;

  logic [31:0]      mem_q [DELAY];
  logic             mem_we;
  logic [31:0]      mem_d;

  logic             phase;
  logic [TW_W-1:0]  k;
  logic [31:0]      head;
  logic [16:0]      s_re, s_im, d_re, d_im;

  function automatic logic [15:0] fit(input logic [16:0] v);
    fit = SCALE ? v[16:1] : v[15:0];
  endfunction

  // k is cnt mod DELAY; masking keeps DELAY=1 at a constant 0 index.
  assign phase = cnt_q[CNT_W-1];
  assign k     = TW_W'(cnt_q & CNT_W'(DELAY - 1));
  assign head  = mem_q[k];

  always_comb begin
    s_re = {head[31], head[31:16]} + {in_data[31], in_data[31:16]};
    s_im = {head[15], head[15:0]}  + {in_data[15], in_data[15:0]};
    d_re = {head[31], head[31:16]} - {in_data[31], in_data[31:16]};
    d_im = {head[15], head[15:0]}  - {in_data[15], in_data[15:0]};
  end

  always_comb begin
    cnt_d        = cnt_q;
    primed_d     = primed_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    out_tw_en_d  = out_tw_en_q;
    out_tw_idx_d = out_tw_idx_q;
    mem_we       = 1'b0;
    mem_d        = in_data;
    if (in_valid) begin
      cnt_d  = cnt_q + 1'b1;
      mem_we = 1'b1;
      if (!phase) begin
        out_data_d   = head;
        out_tw_en_d  = 1'b1;
        out_tw_idx_d = k;
        out_valid_d  = primed_q;
      end else begin
        mem_d        = {fit(d_re), fit(d_im)};
        out_data_d   = {fit(s_re), fit(s_im)};
        out_tw_en_d  = 1'b0;
        out_tw_idx_d = '0;
        out_valid_d  = 1'b1;
        primed_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      primed_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_tw_en_q  <= 1'b0;
      out_tw_idx_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      primed_q     <= primed_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_tw_en_q  <= out_tw_en_d;
      out_tw_idx_q <= out_tw_idx_d;
    end
  end

  // Delay-line storage is deliberately unreset; primed gates any stale head.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[k] <= mem_d;
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_tw_en  = out_tw_en_q;
  assign out_tw_idx = out_tw_idx_q;

endmodule

// File: tb/tb_fft_r2sdf_stage_32b.sv
// Directed bench: two DELAY=4 stages (unscaled and scaled) driven by the same stream.
module tb_fft_r2sdf_stage_32b;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;

  logic        v0, v1, te0, te1;
  logic [31:0] d0, d1;
  logic [1:0]  ti0, ti1;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  fft_r2sdf_stage_32b #(.DELAY(4), .SCALE(1'b0)) u_s0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(v0), .out_data(d0), .out_tw_en(te0), .out_tw_idx(ti0)
  );

  fft_r2sdf_stage_32b #(.DELAY(4), .SCALE(1'b1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(v1), .out_data(d1), .out_tw_en(te1), .out_tw_idx(ti1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, '0);
    rst = 1'b0;
  endtask

  // Priming stream: real 0..7 then four zero samples to flush the differences.
  task automatic run_prime(input string name, input bit gapped);
    logic [31:0] sum0 [4];
    logic [31:0] sum1 [4];
    logic [31:0] last0, last1, din;
    bit          known;
    sum0[0] = 32'h0004_0000; sum0[1] = 32'h0006_0000;
    sum0[2] = 32'h0008_0000; sum0[3] = 32'h000A_0000;
    sum1[0] = 32'h0002_0000; sum1[1] = 32'h0003_0000;
    sum1[2] = 32'h0004_0000; sum1[3] = 32'h0005_0000;
    last0 = '0; last1 = '0; known = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (gapped) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          step(1'b0, $urandom);
          check($sformatf("%s_idle_v0_%0d", name, i), 32'(v0), 32'd0);
          check($sformatf("%s_idle_v1_%0d", name, i), 32'(v1), 32'd0);
          if (known) begin
            check($sformatf("%s_hold_d0_%0d", name, i), d0, last0);
            check($sformatf("%s_hold_d1_%0d", name, i), d1, last1);
          end
        end
      end
      din = (i < 8) ? {16'(i), 16'h0000} : 32'h0;
      step(1'b1, din);
      if (i < 4) begin
        check($sformatf("%s_nv0_%0d", name, i), 32'(v0), 32'd0);
        check($sformatf("%s_nv1_%0d", name, i), 32'(v1), 32'd0);
      end else begin
        if (i < 8) begin
          last0 = sum0[i-4];
          last1 = sum1[i-4];
        end else begin
          last0 = 32'hFFFC_0000;
          last1 = 32'hFFFE_0000;
        end
        known = 1'b1;
        check($sformatf("%s_v0_%0d", name, i), 32'(v0), 32'd1);
        check($sformatf("%s_v1_%0d", name, i), 32'(v1), 32'd1);
        check($sformatf("%s_d0_%0d", name, i), d0, last0);
        check($sformatf("%s_d1_%0d", name, i), d1, last1);
        check($sformatf("%s_te0_%0d", name, i), 32'(te0), (i < 8) ? 32'd0 : 32'd1);
        check($sformatf("%s_te1_%0d", name, i), 32'(te1), (i < 8) ? 32'd0 : 32'd1);
        check($sformatf("%s_ti0_%0d", name, i), 32'(ti0), (i < 8) ? 32'd0 : 32'(i - 8));
        check($sformatf("%s_ti1_%0d", name, i), 32'(ti1), (i < 8) ? 32'd0 : 32'(i - 8));
      end
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0;
    @(posedge clk); #1;

    // Reset held with live input traffic.
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, $urandom);
      check("rst_v0", 32'(v0), 32'd0);
      check("rst_v1", 32'(v1), 32'd0);
      check("rst_d0", d0, 32'd0);
      check("rst_d1", d1, 32'd0);
      check("rst_te0", 32'(te0), 32'd0);
      check("rst_ti0", 32'(ti0), 32'd0);
    end
    rst = 1'b0;
    step(1'b0, '0);
    check("post_rst_v0", 32'(v0), 32'd0);
    check("post_rst_d1", d1, 32'd0);
    check("post_rst_te1", 32'(te1), 32'd0);

    run_prime("prime", 1'b0);

    // Odd / negative-floor sums, then overflow and wrap on the real part.
    do_reset();
    step(1'b1, 32'h0003_FFFD);
    for (int i = 0; i < 3; i++) step(1'b1, '0);
    step(1'b1, '0);
    check("odd_sum0", d0, 32'h0003_FFFD);
    check("odd_sum1", d1, 32'h0001_FFFE);
    for (int i = 0; i < 3; i++) step(1'b1, '0);
    step(1'b1, 32'h7FFF_0000);
    check("odd_diff0", d0, 32'h0003_FFFD);
    check("odd_diff1", d1, 32'h0001_FFFE);
    check("odd_diff_te", 32'(te0), 32'd1);
    check("odd_diff_v1", 32'(v1), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, '0);
    step(1'b1, 32'h0001_0000);
    check("ovf_sum0", d0, 32'h8000_0000);
    check("ovf_sum1", d1, 32'h4000_0000);
    for (int i = 0; i < 3; i++) step(1'b1, '0);
    step(1'b1, '0);
    check("ovf_diff0", d0, 32'h7FFE_0000);
    check("ovf_diff1", d1, 32'h3FFF_0000);
    check("ovf_diff_ti", 32'(ti1), 32'd0);

    do_reset();
    run_prime("gap", 1'b1);

    // Abort a frame after input 6, with rst overriding a valid sample.
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, {16'(i), 16'h0000});
    rst = 1'b1;
    step(1'b1, $urandom);
    rst = 1'b0;
    check("mid_rst_v0", 32'(v0), 32'd0);
    check("mid_rst_d0", d0, 32'd0);
    run_prime("replay", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
